out_deser: RTL and testbench

Downstream capture stage for the clock-tree test core's single-bit registered output. Samples the serial `out` stream on each enabled clock edge, packs bits MSB-first into WIDTH-bit words, and offers each completed word through a valid/ready handshake to the scan/readout logic. It also keeps a saturating count of sampled ones and a sticky overflow flag for words lost to back-pressure.

---
 rtl/out_deser_if.sv | 26 ++
 rtl/out_deser.sv | 99 +++++++++
 tb/tb_out_deser.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/out_deser_if.sv
// Word-stream bundle between the serial capture stage and the readout logic.
// master = capture stage (out_deser), slave = sample source / word consumer.
interface out_deser_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic             din;
    logic             clr;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [CNT_W-1:0] ones_cnt;
    logic             overflow;
    logic             word_parity;

    modport master (
        input  en, din, clr, word_ready,
        output word, word_valid, ones_cnt, overflow, word_parity
    );

    modport slave (
        output en, din, clr, word_ready,
        input  word, word_valid, ones_cnt, overflow, word_parity
    );
endinterface

// File: rtl/out_deser.sv
// Serial-to-parallel capture of the test core output: MSB-first packing, valid/ready
// word hand-off, saturating ones count, sticky overflow. Optional parity: OUT_DESER_PARITY_EN.
module out_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    out_deser_if.master  bus
);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic [CNT_W-1:0] ones_q;
    logic             ovf_q;

    logic             sample;
    logic             complete;
    logic             load;
    logic             drop;
    logic             release_w;
    logic [WIDTH-1:0] word_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.en) state_nxt = SHIFT;
                SHIFT:   if (bus.en && bcnt == BW'(WIDTH-1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // clr wins over a same-edge sample, so the bit is neither shifted nor counted
    always_comb begin
        sample    = bus.en && !bus.clr;
        complete  = sample && (state == SHIFT) && (bcnt == BW'(WIDTH-1));
        word_next = {sh[WIDTH-2:0], bus.din};
        load      = complete && (!valid_q || bus.word_ready);
        drop      = complete && valid_q && !bus.word_ready;
        release_w = !complete && valid_q && bus.word_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            bcnt    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ones_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.clr) begin
                bcnt <= '0;
            end else if (sample) begin
                sh   <= word_next;
                bcnt <= complete ? '0 : bcnt + BW'(1);
                if (bus.din && ones_q != '1) ones_q <= ones_q + CNT_W'(1);
            end
            if (load) begin
                word_q  <= word_next;
                valid_q <= 1'b1;
            end else if (release_w) begin
                valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef OUT_DESER_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       par_q <= 1'b0;
        else if (load) par_q <= ^word_next;
    end
    assign bus.word_parity = par_q;
`else
    assign bus.word_parity = 1'b0;
`endif

    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.ones_cnt   = ones_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_out_deser.sv
// Directed self-checking bench for out_deser (8-bit words; second instance with 4-bit counter).
module tb_out_deser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    out_deser_if #(.WIDTH(8), .CNT_W(16)) a ();
    out_deser_if #(.WIDTH(8), .CNT_W(4))  b ();

    out_deser #(.WIDTH(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
    out_deser #(.WIDTH(8), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(b));

    function automatic logic exp_par(input logic p);
`ifdef OUT_DESER_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic d, input logic c, input logic r);
        a.en = e; a.din = d; a.clr = c; a.word_ready = r;
        @(posedge clk);
        #1;
    endtask

    // MSB first; ready held at rall, or raised only on the completing bit via rlast
    task automatic feed(input logic [7:0] v, input logic rall, input logic rlast);
        for (int i = 7; i >= 0; i--)
            step(1'b1, v[i], 1'b0, rall | (rlast && i == 0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_word"},  32'(a.word), 32'h0);
        chk({tag, "_valid"}, 32'(a.word_valid), 32'h0);
        chk({tag, "_ones"},  32'(a.ones_cnt), 32'h0);
        chk({tag, "_ovf"},   32'(a.overflow), 32'h0);
        chk({tag, "_par"},   32'(a.word_parity), 32'h0);
    endtask

    initial begin
        a.en = 0; a.din = 0; a.clr = 0; a.word_ready = 0;
        b.en = 0; b.din = 0; b.clr = 0; b.word_ready = 0;
        #1;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // pack 8'hB2, no consumer
        for (int i = 0; i < 7; i++) step(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        chk("pre_latency_valid", 32'(a.word_valid), 32'h0);
        a.en = 0;
        // redo with the exact sequence after flushing the partial word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed(8'hB2, 1'b0, 1'b0);
        chk("pack_word",  32'(a.word), 32'hB2);
        chk("pack_valid", 32'(a.word_valid), 32'h1);
        chk("pack_ones",  32'(a.ones_cnt), 32'd8);
        chk("pack_ovf",   32'(a.overflow), 32'h0);
        chk("pack_par",   32'(a.word_parity), 32'(exp_par(1'b0)));

        // back-pressure drop
        feed(8'hFF, 1'b0, 1'b0);
        chk("drop_word", 32'(a.word), 32'hB2);
        chk("drop_ovf",  32'(a.overflow), 32'h1);
        chk("drop_ones", 32'(a.ones_cnt), 32'd16);

        // complete + accept on the same edge
        feed(8'h0F, 1'b0, 1'b1);
        chk("cpa_word",  32'(a.word), 32'h0F);
        chk("cpa_valid", 32'(a.word_valid), 32'h1);
        chk("cpa_ovf",   32'(a.overflow), 32'h1);
        chk("cpa_ones",  32'(a.ones_cnt), 32'd20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rel_valid", 32'(a.word_valid), 32'h0);
        chk("rel_word",  32'(a.word), 32'h0F);

        // pause: 1,1,0 / 5 idle cycles with din=1 / 0,0,1,1,1 -> 8'hC7
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("pause_valid", 32'(a.word_valid), 32'h0);
        chk("pause_ones",  32'(a.ones_cnt), 32'd22);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pause_word",  32'(a.word), 32'hC7);
        chk("pause_valid2", 32'(a.word_valid), 32'h1);
        chk("pause_ones2", 32'(a.ones_cnt), 32'd25);
        chk("pause_par",   32'(a.word_parity), 32'(exp_par(1'b1)));

        // flush: 3 bits, clr with a competing sample, then 8'hA5
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_ones",  32'(a.ones_cnt), 32'd28);
        chk("clr_valid", 32'(a.word_valid), 32'h1);
        chk("clr_word",  32'(a.word), 32'hC7);
        chk("clr_ovf",   32'(a.overflow), 32'h1);
        feed(8'hA5, 1'b0, 1'b1);
        chk("flush_word", 32'(a.word), 32'hA5);
        chk("flush_ones", 32'(a.ones_cnt), 32'd32);
        chk("flush_par",  32'(a.word_parity), 32'(exp_par(1'b0)));

        // sustained rate with ready high
        feed(8'h07, 1'b1, 1'b0);
        chk("sus1_word",  32'(a.word), 32'h07);
        chk("sus1_valid", 32'(a.word_valid), 32'h1);
        chk("sus1_par",   32'(a.word_parity), 32'(exp_par(1'b1)));
        feed(8'h55, 1'b1, 1'b0);
        chk("sus2_word",  32'(a.word), 32'h55);
        chk("sus2_valid", 32'(a.word_valid), 32'h1);
        chk("sus2_ones",  32'(a.ones_cnt), 32'd39);
        chk("sus2_ovf",   32'(a.overflow), 32'h1);

        // saturation on the 4-bit counter instance
        b.en = 1; b.din = 1; b.word_ready = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 13) chk("sat_14", 32'(b.ones_cnt), 32'd14);
        end
        b.en = 0;
        chk("sat_ones",  32'(b.ones_cnt), 32'd15);
        chk("sat_word",  32'(b.word), 32'hFF);
        chk("sat_valid", 32'(b.word_valid), 32'h0);

        // async reset after 5 bits of a word
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_zero("midrst");
        a.en = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 7; i >= 1; i--) step(1'b1, i[0] ? 1'b1 : 1'b0, 1'b0, 1'b0);
        chk("post_rst_7bits_valid", 32'(a.word_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_word",  32'(a.word), 32'hAA);
        chk("post_rst_valid", 32'(a.word_valid), 32'h1);
        chk("post_rst_ones",  32'(a.ones_cnt), 32'd4);
        chk("post_rst_ovf",   32'(a.overflow), 32'h0);
        chk("post_rst_par",   32'(a.word_parity), 32'(exp_par(1'b0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
